muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M execution unit with a two-stage pipelined multiplier and a 32-cycle restoring divider.
// The divider is built only when MULDIV_DIV_EN is defined; otherwise DIV-class ops write back 0.
module muldiv_ctrl (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] inst_i,
   input  logic [31:0] rs1_value_i,
   input  logic [31:0] rs2_value_i,
   input  logic [4:0]  rob_idx_i,
   input  logic        flush_i,
   output logic        wb_valid_o,
   output logic [31:0] wb_value_o,
   output logic [4:0]  wb_rob_idx_o
);
   logic [2:0]  f3;
   logic        accept, s1_load, s1_valid, s1_hi, div_wb, wb_take, unused;
   logic [32:0] s1_a, s1_b;
   logic [4:0]  s1_tag, div_tag;
   logic [31:0] div_res;
   logic [63:0] prod;

   assign f3      = inst_i[14:12];
   assign unused  = ^{inst_i[31:15], inst_i[11:0]};
   assign accept  = req_valid_i && req_ready_o && !flush_i;
   assign prod    = $signed({{31{s1_a[32]}}, s1_a}) * $signed({{31{s1_b[32]}}, s1_b});
   assign wb_take = !flush_i && (s1_valid || div_wb);

   // DIV-class operands are zeroed so a divider-less build writes back 0 through S1
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) s1_valid <= 1'b0;
      else s1_valid <= s1_load;
      if (s1_load) begin
         s1_a   <= f3[2] ? '0 : {(f3[1] ^ f3[0]) & rs1_value_i[31], rs1_value_i};
         s1_b   <= f3[2] ? '0 : {(f3[1:0] == 2'b01) & rs2_value_i[31], rs2_value_i};
         s1_hi  <= |f3[1:0];
         s1_tag <= rob_idx_i;
      end
   end

`ifdef MULDIV_DIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
   div_state_t  state, state_n;
   logic        sgn, special, div_acc, ge, neg_q, neg_r, is_rem;
   logic [31:0] quo, rem, dvs, a_abs, b_abs;
   logic [32:0] sh;
   logic [4:0]  cnt;

   assign sgn         = !f3[0];
   assign div_acc     = accept && f3[2];
   assign special     = rs2_value_i == 32'h0 ||
                        (sgn && rs1_value_i == 32'h80000000 && rs2_value_i == 32'hFFFFFFFF);
   assign a_abs       = (sgn && rs1_value_i[31]) ? -rs1_value_i : rs1_value_i;
   assign b_abs       = (sgn && rs2_value_i[31]) ? -rs2_value_i : rs2_value_i;
   assign sh          = {rem, quo[31]};
   assign ge          = sh >= {1'b0, dvs};
   assign div_res     = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   assign div_wb      = state == DONE && !s1_valid;
   assign req_ready_o = !f3[2] || state == IDLE;
   assign s1_load     = accept && !f3[2];

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (flush_i) state_n = IDLE;
      else if (state == IDLE && div_acc) state_n = special ? DONE : BUSY;
      else if (state == BUSY && cnt == 5'd31) state_n = DONE;
      else if (div_wb) state_n = IDLE;
   end

   // Special cases preload quotient/remainder with no sign fix-up and skip BUSY
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) cnt <= '0;
      else if (div_acc) cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 5'd1;
      if (div_acc) begin
         div_tag <= rob_idx_i;
         is_rem  <= f3[1];
         dvs     <= b_abs;
         quo     <= special ? (rs2_value_i == 32'h0 ? 32'hFFFFFFFF : 32'h80000000) : a_abs;
         rem     <= (special && rs2_value_i == 32'h0) ? rs1_value_i : 32'h0;
         neg_q   <= !special && sgn && (rs1_value_i[31] ^ rs2_value_i[31]);
         neg_r   <= !special && sgn && rs1_value_i[31];
      end else if (state == BUSY) begin
         quo <= {quo[30:0], ge};
         rem <= ge ? 32'(sh - {1'b0, dvs}) : sh[31:0];
      end
   end
`else
   assign req_ready_o = 1'b1;
   assign s1_load     = accept;
   assign div_wb      = 1'b0;
   assign div_res     = '0;
   assign div_tag     = '0;
`endif

   // A valid S1 product always wins; the divider waits in DONE
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wb_valid_o   <= 1'b0;
         wb_value_o   <= '0;
         wb_rob_idx_o <= '0;
      end else begin
         wb_valid_o <= wb_take;
         if (wb_take) begin
            wb_value_o   <= s1_valid ? (s1_hi ? prod[63:32] : prod[31:0]) : div_res;
            wb_rob_idx_o <= s1_valid ? s1_tag : div_tag;
         end
      end
   end
endmodule
